// File: rtl/iact_tx_pkg.sv
// Shared widths and FSM encoding for the router-side iact transmitter.
package iact_tx_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 13;
    localparam int SRAM_AW = 10;
    localparam int LEN_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/iact_tx_fifo2.sv
// Two-entry FIFO with occupancy count; storage clears on reset so the head reads zero.
module iact_tx_fifo2 #(
    parameter int W = iact_tx_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/iact_router_tx.sv
// Streams one CSC iact tile (address vector, then data vector) from GLB SRAM
// onto a router port's valid/ready address and data channels.
module iact_router_tx #(
    parameter int ADDR_W  = iact_tx_pkg::ADDR_W,
    parameter int DATA_W  = iact_tx_pkg::DATA_W,
    parameter int SRAM_AW = iact_tx_pkg::SRAM_AW,
    parameter int LEN_W   = iact_tx_pkg::LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SRAM_AW-1:0] addr_base,
    input  logic [LEN_W-1:0]   addr_len,
    input  logic [SRAM_AW-1:0] data_base,
    input  logic [LEN_W-1:0]   data_len,
    output logic               busy,
    output logic               done,
    output logic               addr_rd_en,
    output logic [SRAM_AW-1:0] addr_rd_addr,
    input  logic [ADDR_W-1:0]  addr_rd_data,
    output logic               data_rd_en,
    output logic [SRAM_AW-1:0] data_rd_addr,
    input  logic [DATA_W-1:0]  data_rd_data,
    output logic               iact_address_out_valid,
    input  logic               iact_address_out_ready,
    output logic [ADDR_W-1:0]  iact_address_out_bits,
    output logic               iact_data_out_valid,
    input  logic               iact_data_out_ready,
    output logic [DATA_W-1:0]  iact_data_out_bits
);

    import iact_tx_pkg::*;

    tx_state_e          state;
    logic [SRAM_AW-1:0] addr_base_q, data_base_q;
    logic [LEN_W-1:0]   addr_len_q, data_len_q;
    logic [LEN_W-1:0]   addr_rd_idx, data_rd_idx;
    logic [LEN_W-1:0]   addr_sent, data_sent;
    logic               addr_inflight, data_inflight;
    logic [1:0]         addr_count, data_count;
    logic [2:0]         addr_occ, data_occ;
    logic               addr_pop, data_pop;
    logic               addr_last, data_last;

    assign addr_pop  = iact_address_out_valid && iact_address_out_ready;
    assign data_pop  = iact_data_out_valid && iact_data_out_ready;
    assign addr_last = addr_pop && (addr_sent == addr_len_q - LEN_W'(1));
    assign data_last = data_pop && (data_sent == data_len_q - LEN_W'(1));

    // Credit: buffered words plus the one in flight, less what leaves this cycle, must stay under 2.
    assign addr_occ = 3'(addr_count) + 3'(addr_inflight) - 3'(addr_pop);
    assign data_occ = 3'(data_count) + 3'(data_inflight) - 3'(data_pop);

    assign addr_rd_en   = (state == ADDR) && (addr_rd_idx != addr_len_q) && (addr_occ < 3'd2);
    assign data_rd_en   = (state == DATA) && (data_rd_idx != data_len_q) && (data_occ < 3'd2);
    assign addr_rd_addr = addr_base_q + SRAM_AW'(addr_rd_idx);
    assign data_rd_addr = data_base_q + SRAM_AW'(data_rd_idx);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign iact_address_out_valid = (addr_count != 2'd0);
    assign iact_data_out_valid    = (data_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_base_q   <= '0;
            data_base_q   <= '0;
            addr_len_q    <= '0;
            data_len_q    <= '0;
            addr_rd_idx   <= '0;
            data_rd_idx   <= '0;
            addr_sent     <= '0;
            data_sent     <= '0;
            addr_inflight <= 1'b0;
            data_inflight <= 1'b0;
        end else begin
            addr_inflight <= addr_rd_en;
            data_inflight <= data_rd_en;
            if (addr_rd_en) addr_rd_idx <= addr_rd_idx + LEN_W'(1);
            if (data_rd_en) data_rd_idx <= data_rd_idx + LEN_W'(1);
            if (addr_pop)   addr_sent   <= addr_sent + LEN_W'(1);
            if (data_pop)   data_sent   <= data_sent + LEN_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        addr_base_q <= addr_base;
                        data_base_q <= data_base;
                        addr_len_q  <= addr_len;
                        data_len_q  <= data_len;
                        addr_rd_idx <= '0;
                        data_rd_idx <= '0;
                        addr_sent   <= '0;
                        data_sent   <= '0;
                        if (addr_len != '0)      state <= ADDR;
                        else if (data_len != '0) state <= DATA;
                        else                     state <= DONE;
                    end
                end
                ADDR: begin
                    if (addr_last) state <= (data_len_q != '0) ? DATA : DONE;
                end
                DATA: begin
                    if (data_last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    iact_tx_fifo2 #(.W(ADDR_W)) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (addr_inflight),
        .push_data (addr_rd_data),
        .pop       (addr_pop),
        .head      (iact_address_out_bits),
        .count     (addr_count)
    );

    iact_tx_fifo2 #(.W(DATA_W)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_inflight),
        .push_data (data_rd_data),
        .pop       (data_pop),
        .head      (iact_data_out_bits),
        .count     (data_count)
    );

endmodule

// File: tb/tb_iact_router_tx.sv
// Self-checking bench for iact_router_tx: random SRAM contents and random
// backpressure, checked against word queues built from the tile layout.
module tb_iact_router_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  addr_base;
    logic [9:0]  addr_len;
    logic [9:0]  data_base;
    logic [9:0]  data_len;
    logic        busy;
    logic        done;
    logic        addr_rd_en;
    logic [9:0]  addr_rd_addr;
    logic [7:0]  addr_rd_data;
    logic        data_rd_en;
    logic [9:0]  data_rd_addr;
    logic [12:0] data_rd_data;
    logic        iact_address_out_valid;
    logic        iact_address_out_ready;
    logic [7:0]  iact_address_out_bits;
    logic        iact_data_out_valid;
    logic        iact_data_out_ready;
    logic [12:0] iact_data_out_bits;

    logic [7:0]  addr_mem [1024];
    logic [12:0] data_mem [1024];

    int          vectors;
    int          miscompares;
    logic [9:0]  last_addr_rd_addr;

    iact_router_tx dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .addr_base              (addr_base),
        .addr_len               (addr_len),
        .data_base              (data_base),
        .data_len               (data_len),
        .busy                   (busy),
        .done                   (done),
        .addr_rd_en             (addr_rd_en),
        .addr_rd_addr           (addr_rd_addr),
        .addr_rd_data           (addr_rd_data),
        .data_rd_en             (data_rd_en),
        .data_rd_addr           (data_rd_addr),
        .data_rd_data           (data_rd_data),
        .iact_address_out_valid (iact_address_out_valid),
        .iact_address_out_ready (iact_address_out_ready),
        .iact_address_out_bits  (iact_address_out_bits),
        .iact_data_out_valid    (iact_data_out_valid),
        .iact_data_out_ready    (iact_data_out_ready),
        .iact_data_out_bits     (iact_data_out_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency SRAMs; garbage on idle cycles exposes any stray FIFO write.
    always @(posedge clk) begin
        addr_rd_data <= addr_rd_en ? addr_mem[addr_rd_addr] : 8'($urandom);
        data_rd_data <= data_rd_en ? data_mem[data_rd_addr] : 13'($urandom);
    end

    task automatic run_transfer(input logic [9:0] abase, input int alen,
                                input logic [9:0] dbase, input int dlen,
                                input bit rand_ready, input bit restart_in_data);
        logic [7:0]  exp_a[$];
        logic [12:0] exp_d[$];
        logic [7:0]  prev_a_bits;
        logic [12:0] prev_d_bits;
        bit prev_a_stall, prev_d_stall, restarted, finished, a_pop, d_pop, seen_a_valid, exp_busy;
        int cyc, a_rd, d_rd, a_hs, d_hs, dones, done_cyc, last_a_hs, last_d_hs, exp_done;

        for (int i = 0; i < alen; i++) exp_a.push_back(addr_mem[(int'(abase) + i) % 1024]);
        for (int i = 0; i < dlen; i++) exp_d.push_back(data_mem[(int'(dbase) + i) % 1024]);
        prev_a_stall = 0; prev_d_stall = 0; restarted = 0; finished = 0; seen_a_valid = 0;
        prev_a_bits = '0; prev_d_bits = '0;
        a_rd = 0; d_rd = 0; a_hs = 0; d_hs = 0; dones = 0; done_cyc = -1;
        last_a_hs = -1; last_d_hs = -1; cyc = 0;

        start     = 1'b1;
        addr_base = abase;
        addr_len  = 10'(alen);
        data_base = dbase;
        data_len  = 10'(dlen);
        iact_address_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        iact_data_out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            a_pop = iact_address_out_valid && iact_address_out_ready;
            d_pop = iact_data_out_valid && iact_data_out_ready;

            if (cyc == 1 && alen > 0) begin
                vectors++;
                if (addr_rd_en !== 1'b1 || busy !== 1'b1)
                    $display("[TB] FAIL cycle1_issue: addr_rd_en=%b busy=%b, required 1 and 1", addr_rd_en, busy);
                if (addr_rd_en !== 1'b1 || busy !== 1'b1) miscompares++;
            end

            if (addr_rd_en === 1'b1) begin
                vectors++;
                if (a_rd >= alen || addr_rd_addr !== 10'((int'(abase) + a_rd) % 1024) || (a_rd - a_hs - int'(a_pop)) >= 2) begin
                    miscompares++;
                    $display("[TB] FAIL addr_read: cyc=%0d addr=%h required %h, issued=%0d of %0d, outstanding=%0d (must be <2)",
                             cyc, addr_rd_addr, 10'((int'(abase) + a_rd) % 1024), a_rd, alen, a_rd - a_hs - int'(a_pop));
                end
                last_addr_rd_addr = addr_rd_addr;
                a_rd++;
            end

            if (data_rd_en === 1'b1) begin
                vectors++;
                if (d_rd >= dlen || a_hs != alen || data_rd_addr !== 10'((int'(dbase) + d_rd) % 1024) || (d_rd - d_hs - int'(d_pop)) >= 2) begin
                    miscompares++;
                    $display("[TB] FAIL data_read: cyc=%0d addr=%h required %h, issued=%0d of %0d, addr words sent=%0d of %0d, outstanding=%0d",
                             cyc, data_rd_addr, 10'((int'(dbase) + d_rd) % 1024), d_rd, dlen, a_hs, alen, d_rd - d_hs - int'(d_pop));
                end
                d_rd++;
            end

            vectors++;
            if ((iact_address_out_valid === 1'b1 && iact_data_out_valid === 1'b1) ||
                (iact_data_out_valid === 1'b1 && a_hs < alen)) begin
                miscompares++;
                $display("[TB] FAIL channel_order: cyc=%0d addr_valid=%b data_valid=%b addr words sent=%0d of %0d, required data idle until address done",
                         cyc, iact_address_out_valid, iact_data_out_valid, a_hs, alen);
            end

            if (iact_address_out_valid === 1'b1 && !seen_a_valid) begin
                seen_a_valid = 1;
                vectors++;
                if (cyc != 3) begin
                    miscompares++;
                    $display("[TB] FAIL first_addr_valid: cycle %0d, required 3", cyc);
                end
            end

            if (prev_a_stall) begin
                vectors++;
                if (iact_address_out_valid !== 1'b1 || iact_address_out_bits !== prev_a_bits) begin
                    miscompares++;
                    $display("[TB] FAIL addr_stable: valid=%b bits=%h, required 1 and %h", iact_address_out_valid, iact_address_out_bits, prev_a_bits);
                end
            end
            if (prev_d_stall) begin
                vectors++;
                if (iact_data_out_valid !== 1'b1 || iact_data_out_bits !== prev_d_bits) begin
                    miscompares++;
                    $display("[TB] FAIL data_stable: valid=%b bits=%h, required 1 and %h", iact_data_out_valid, iact_data_out_bits, prev_d_bits);
                end
            end
            prev_a_stall = (iact_address_out_valid === 1'b1) && !iact_address_out_ready;
            prev_d_stall = (iact_data_out_valid === 1'b1) && !iact_data_out_ready;
            prev_a_bits  = iact_address_out_bits;
            prev_d_bits  = iact_data_out_bits;

            if (a_pop) begin
                vectors++;
                if (exp_a.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL addr_word: extra word %h, required none", iact_address_out_bits);
                end else begin
                    if (iact_address_out_bits !== exp_a[0] || (!rand_ready && last_a_hs >= 0 && cyc != last_a_hs + 1)) begin
                        miscompares++;
                        $display("[TB] FAIL addr_word: word %0d = %h at cyc %0d, required %h (previous at %0d)",
                                 a_hs, iact_address_out_bits, cyc, exp_a[0], last_a_hs);
                    end
                    void'(exp_a.pop_front());
                end
                last_a_hs = cyc;
                a_hs++;
            end

            if (d_pop) begin
                vectors++;
                exp_done = (last_d_hs >= 0) ? last_d_hs + 1 : ((alen > 0) ? last_a_hs + 3 : 3);
                if (exp_d.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL data_word: extra word %h, required none", iact_data_out_bits);
                end else begin
                    if (iact_data_out_bits !== exp_d[0] || (!rand_ready && cyc != exp_done)) begin
                        miscompares++;
                        $display("[TB] FAIL data_word: word %0d = %h at cyc %0d, required %h at cyc %0d",
                                 d_hs, iact_data_out_bits, cyc, exp_d[0], exp_done);
                    end
                    void'(exp_d.pop_front());
                end
                last_d_hs = cyc;
                d_hs++;
            end

            if (done === 1'b1) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    exp_done = (dlen > 0) ? last_d_hs + 1 : ((alen > 0) ? last_a_hs + 1 : 1);
                    vectors++;
                    if (cyc != exp_done) begin
                        miscompares++;
                        $display("[TB] FAIL done_time: done at cyc %0d, required %0d", cyc, exp_done);
                    end
                end
            end

            exp_busy = (cyc >= 1) && (done_cyc < 0 || cyc == done_cyc);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL busy: cyc=%0d busy=%b, required %b", cyc, busy, exp_busy);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) finished = 1;

            @(posedge clk);
            #1;
            start = 1'b0;
            if (restart_in_data && !restarted && d_hs > 0 && done_cyc < 0) begin
                start     = 1'b1;
                addr_base = 10'($urandom);
                addr_len  = 10'd5;
                data_base = 10'($urandom);
                data_len  = 10'd7;
                restarted = 1;
            end
            iact_address_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            iact_data_out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end

        vectors++;
        if (!finished) begin
            miscompares++;
            $display("[TB] FAIL timeout: transfer not complete after %0d cycles, required done", cyc);
        end
        vectors++;
        if (a_hs != alen || d_hs != dlen || exp_a.size() != 0 || exp_d.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL word_count: addr %0d data %0d, required %0d and %0d", a_hs, d_hs, alen, dlen);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("[TB] FAIL done_count: %0d pulses, required 1", dones);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({busy, done, addr_rd_en, data_rd_en, iact_address_out_valid, iact_data_out_valid} !== 6'b0 ||
            addr_rd_addr !== 10'h0 || data_rd_addr !== 10'h0 ||
            iact_address_out_bits !== 8'h0 || iact_data_out_bits !== 13'h0) begin
            miscompares++;
            $display("[TB] FAIL %s: busy=%b done=%b rd_en=%b%b valid=%b%b rd_addr=%h/%h bits=%h/%h, required all zero",
                     tag, busy, done, addr_rd_en, data_rd_en, iact_address_out_valid, iact_data_out_valid,
                     addr_rd_addr, data_rd_addr, iact_address_out_bits, iact_data_out_bits);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        addr_base = '0; addr_len = '0; data_base = '0; data_len = '0;
        iact_address_out_ready = 1'b0;
        iact_data_out_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset_release");
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_transfer(10'h010, 3, 10'h100, 4, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 3; r++) run_transfer(10'h010, 3, 10'h100, 4, 1'b1, 1'b0);
    endtask

    task automatic test_zero_lengths();
        run_transfer(10'h020, 0, 10'h200, 2, 1'b0, 1'b0);
        run_transfer(10'h000, 0, 10'h000, 0, 1'b0, 1'b0);
        run_transfer(10'h040, 2, 10'h000, 0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        run_transfer(10'h3FE, 4, 10'h3FF, 3, 1'b1, 1'b0);
        vectors++;
        if (last_addr_rd_addr !== 10'h001) begin
            miscompares++;
            $display("[TB] FAIL wrap_last_addr: %h, required 001", last_addr_rd_addr);
        end
    endtask

    task automatic test_restart_in_data();
        run_transfer(10'h050, 2, 10'h060, 5, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++)
            run_transfer(10'($urandom), int'($urandom_range(0, 6)), 10'($urandom),
                         int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_reset_midop();
        start = 1'b1;
        addr_base = 10'h030; addr_len = 10'd4; data_base = 10'h040; data_len = 10'd3;
        iact_address_out_ready = 1'b0;
        iact_data_out_ready    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        // One word buffered, the second returning this cycle, so no further read may issue.
        vectors++;
        if (iact_address_out_valid !== 1'b1 || addr_rd_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midop_setup: valid=%b rd_en=%b busy=%b, required 1 0 1",
                     iact_address_out_valid, addr_rd_en, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        iact_address_out_ready = 1'b1;
        iact_data_out_ready    = 1'b1;
        @(negedge clk);
        check_all_zero("midop_reset");
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_all_zero("post_abort_idle");
        end
        @(posedge clk); #1;
        run_transfer(10'h030, 4, 10'h040, 3, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        last_addr_rd_addr = '0;
        for (int i = 0; i < 1024; i++) begin
            addr_mem[i] = 8'($urandom);
            data_mem[i] = 13'($urandom);
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_lengths();
        test_wrap();
        test_restart_in_data();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
